mc_ctrl_fsm: RTL

//  Multi-cycle MIPS control unit: decodes op/funct, sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath controls.

---
 rtl/mc_pkg.sv | 69 ++++++
 rtl/mc_ctrl_if.sv | 46 ++++
 rtl/mc_decode.sv | 37 +++
 rtl/mc_ctrl_fsm.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit.
// Build option MC_CTRL_JAL_EN adds jal and widens RegDst/MemtoReg.
package mc_pkg;

`ifdef MC_CTRL_JAL_EN
  localparam int SEL_W = 2;
`else
  localparam int SEL_W = 1;
`endif

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_JAL    = 3'd5
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    C_ILL, C_ADDU, C_SUBU, C_AND, C_OR,
    C_SLT, C_ORI, C_LUI, C_LW, C_SW,
    C_BEQ, C_J, C_JAL
  } cls_t;

  typedef struct packed {
    logic             mem_req;
    logic             IorD;
    logic             IRWrite;
    logic             PCWrite;
    logic             nPC_sel;
    logic             jmp;
    logic [SEL_W-1:0] RegDst;
    logic             ALUSrc;
    logic             ExtOp;
    logic [SEL_W-1:0] MemtoReg;
    logic             RegWrite;
    logic             MemWrite;
    logic [2:0]       ALUctr;
    logic             illegal;
  } ctrl_t;

  function automatic logic is_rtype(cls_t c);
    return c inside {C_ADDU, C_SUBU, C_AND, C_OR, C_SLT};
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bundle between the controller (master) and datapath (slave).
// RegDst/MemtoReg width follows MC_CTRL_JAL_EN through mc_pkg.
interface mc_ctrl_if
  import mc_pkg::*;
#(
  parameter int ALUCTR_W = 3,
  parameter int STATE_W  = 3
);
  logic [5:0]          op;
  logic [5:0]          funct;
  logic                zero;
  logic                mem_ready;
  logic                mem_req;
  logic                IorD;
  logic                IRWrite;
  logic                PCWrite;
  logic                nPC_sel;
  logic                jmp;
  logic [SEL_W-1:0]    RegDst;
  logic                ALUSrc;
  logic                ExtOp;
  logic [SEL_W-1:0]    MemtoReg;
  logic                RegWrite;
  logic                MemWrite;
  logic [ALUCTR_W-1:0] ALUctr;
  logic                illegal;
  logic [STATE_W-1:0]  dbg_state;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, IorD, IRWrite, PCWrite,
    output nPC_sel, jmp, RegDst, ALUSrc,
    output ExtOp, MemtoReg, RegWrite,
    output MemWrite, ALUctr, illegal,
    output dbg_state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, IorD, IRWrite, PCWrite,
    input  nPC_sel, jmp, RegDst, ALUSrc,
    input  ExtOp, MemtoReg, RegWrite,
    input  MemWrite, ALUctr, illegal,
    input  dbg_state
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational op/funct -> instruction class decoder.
// jal is recognised only when MC_CTRL_JAL_EN is defined.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic       legal
);
  logic rt;

  assign rt = (op == OP_R);

  always_comb begin
    cls = C_ILL;
    unique case (1'b1)
      (rt && funct == F_ADDU): cls = C_ADDU;
      (rt && funct == F_SUBU): cls = C_SUBU;
      (rt && funct == F_AND):  cls = C_AND;
      (rt && funct == F_OR):   cls = C_OR;
      (rt && funct == F_SLT):  cls = C_SLT;
      (op == OP_ORI):          cls = C_ORI;
      (op == OP_LUI):          cls = C_LUI;
      (op == OP_LW):           cls = C_LW;
      (op == OP_SW):           cls = C_SW;
      (op == OP_BEQ):          cls = C_BEQ;
      (op == OP_J):            cls = C_J;
`ifdef MC_CTRL_JAL_EN
      (op == OP_JAL):          cls = C_JAL;
`endif
      default:                 cls = C_ILL;
    endcase
  end

  assign legal = (cls != C_ILL);
endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing.
// MC_CTRL_JAL_EN adds a JAL link state (RegDst/MemtoReg = 2).
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int ALUCTR_W = 3,
  parameter int STATE_W  = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  mc_ctrl_if.master bus
);
  state_t state;
  cls_t   cls;
  cls_t   dcls;
  logic   dlegal;
  ctrl_t  c;
  ctrl_t  q;

  mc_decode u_dec (
    .op    (bus.op),
    .funct (bus.funct),
    .cls   (dcls),
    .legal (dlegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
      cls   <= C_ILL;
    end else begin
      case (state)
        S_FETCH:
          if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          cls <= dcls;
          if (!dlegal || dcls == C_J)
            state <= S_FETCH;
`ifdef MC_CTRL_JAL_EN
          else if (dcls == C_JAL)
            state <= S_JAL;
`endif
          else
            state <= S_EXEC;
        end
        S_EXEC:
          if (cls == C_LW || cls == C_SW)
            state <= S_MEM;
          else if (is_rtype(cls) ||
                   cls == C_ORI ||
                   cls == C_LUI)
            state <= S_WB;
          else
            state <= S_FETCH;
        S_MEM:
          if (bus.mem_ready)
            state <= (cls == C_LW) ? S_WB : S_FETCH;
        default:
          state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.mem_req = 1'b1;
        c.IRWrite = bus.mem_ready;
        c.PCWrite = bus.mem_ready;
      end
      S_DECODE: begin
        c.illegal = !dlegal;
        if (dcls == C_J) begin
          c.jmp     = 1'b1;
          c.PCWrite = 1'b1;
        end
      end
      S_EXEC:
        case (cls)
          C_SUBU: c.ALUctr = ALU_SUB;
          C_AND:  c.ALUctr = ALU_AND;
          C_OR:   c.ALUctr = ALU_OR;
          C_SLT:  c.ALUctr = ALU_SLT;
          C_ORI: begin
            c.ALUSrc = 1'b1;
            c.ALUctr = ALU_OR;
          end
          C_LUI: begin
            c.ALUSrc = 1'b1;
            c.ALUctr = ALU_LUI;
          end
          C_LW, C_SW: begin
            c.ALUSrc = 1'b1;
            c.ExtOp  = 1'b1;
          end
          C_BEQ: begin
            c.ALUctr  = ALU_SUB;
            c.nPC_sel = 1'b1;
            c.PCWrite = bus.zero;
          end
          default: ;
        endcase
      S_MEM: begin
        c.mem_req  = 1'b1;
        c.IorD     = 1'b1;
        c.MemWrite = (cls == C_SW);
      end
      S_WB: begin
        c.RegWrite = 1'b1;
        c.RegDst   = SEL_W'(is_rtype(cls));
        c.MemtoReg = SEL_W'(cls == C_LW);
      end
`ifdef MC_CTRL_JAL_EN
      S_JAL: begin
        c.RegWrite = 1'b1;
        c.RegDst   = SEL_W'(2);
        c.MemtoReg = SEL_W'(2);
        c.jmp      = 1'b1;
        c.PCWrite  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Reset forces every control low at once, so an access in flight is dropped.
  assign q = rst_n ? c : '0;

  assign bus.mem_req   = q.mem_req;
  assign bus.IorD      = q.IorD;
  assign bus.IRWrite   = q.IRWrite;
  assign bus.PCWrite   = q.PCWrite;
  assign bus.nPC_sel   = q.nPC_sel;
  assign bus.jmp       = q.jmp;
  assign bus.RegDst    = q.RegDst;
  assign bus.ALUSrc    = q.ALUSrc;
  assign bus.ExtOp     = q.ExtOp;
  assign bus.MemtoReg  = q.MemtoReg;
  assign bus.RegWrite  = q.RegWrite;
  assign bus.MemWrite  = q.MemWrite;
  assign bus.ALUctr    = ALUCTR_W'(q.ALUctr);
  assign bus.illegal   = q.illegal;
  assign bus.dbg_state = rst_n ? STATE_W'(state) : '0;
endmodule
